// File: rtl/sm_warp_dispatch_pkg.sv
// sm_warp_dispatch_pkg: shared SM types and default sizes for warp dispatch
package sm_warp_dispatch_pkg;
  localparam int SM_DEPTH_WARP = 8;
  localparam int SM_NUM_WARP = SM_DEPTH_WARP;
  localparam int SM_CODE_ADDR_WIDTH = 32;
  typedef enum logic [1:0] {W_FREE, W_PEND, W_RUN, W_DONE} warp_state_e;
endpackage

// File: rtl/sm_wid_fifo.sv
// sm_wid_fifo: power-of-two FIFO of warp ids, head shown combinationally
module sm_wid_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 3,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] rd_q, wr_q;
  logic [AW:0] cnt_q;
  logic push_ok, pop_ok;
  assign valid_o = cnt_q != '0;
  assign data_o = valid_o ? mem_q[rd_q] : '0;
  assign push_ok = push_i && (cnt_q != (AW+1)'(DEPTH));
  assign pop_ok = pop_i && valid_o;
  // pointers and occupancy; push and pop in one cycle both apply
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q <= '0;
      wr_q <= '0;
      cnt_q <= '0;
    end else begin
      rd_q <= rd_q + AW'(pop_ok);
      wr_q <= wr_q + AW'(push_ok);
      cnt_q <= cnt_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end
  end
  // storage needs no reset: data_o is masked while empty
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q] <= data_i;
  end
endmodule

// File: rtl/sm_warp_dispatch.sv
// sm_warp_dispatch: warp slot allocator/launcher/completion queue; SM_WARP_DISPATCH_RR_EN selects round-robin allocation
module sm_warp_dispatch
  import sm_warp_dispatch_pkg::*;
#(
  parameter int NUM_WARP = SM_NUM_WARP,
  parameter int CODE_ADDR_WIDTH = SM_CODE_ADDR_WIDTH,
  localparam int WID_W = $clog2(NUM_WARP)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       tpc_req_valid_i,
  output logic                       tpc_req_ready_o,
  input  logic [CODE_ADDR_WIDTH-1:0] tpc_req_start_addr_i,
  output logic                       tpc_rsp_valid_o,
  input  logic                       tpc_rsp_ready_i,
  output logic [WID_W-1:0]           tpc_rsp_wid_o,
  output logic                       warp_launch_valid_o,
  input  logic                       warp_launch_ready_i,
  output logic [WID_W-1:0]           warp_launch_wid_o,
  output logic [CODE_ADDR_WIDTH-1:0] warp_launch_addr_o,
  input  logic                       warp_done_valid_i,
  input  logic [WID_W-1:0]           warp_done_wid_i,
  output logic [NUM_WARP-1:0]        warp_active_o
);
  warp_state_e state_q [NUM_WARP];
  warp_state_e state_d [NUM_WARP];
  logic lv_q, lv_d;
  logic [WID_W-1:0] lwid_q, lwid_d, sel;
  logic [CODE_ADDR_WIDTH-1:0] laddr_q, laddr_d;
  logic any_free, req_fire, launch_fire, done_hit, rsp_fire;
`ifdef SM_WARP_DISPATCH_RR_EN
  logic [WID_W-1:0] ptr_q, ptr_d;
  // first FREE slot after the last allocated one, wrapping; ptr itself is checked last
  always_comb begin
    any_free = 1'b0;
    sel = '0;
    for (int k = NUM_WARP; k >= 1; k--)
      if (state_q[ptr_q + WID_W'(k)] == W_FREE) begin
        any_free = 1'b1;
        sel = ptr_q + WID_W'(k);
      end
    ptr_d = req_fire ? sel : ptr_q;
  end
  // allocation pointer starts so that slot 0 is searched first
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= WID_W'(NUM_WARP - 1);
    else ptr_q <= ptr_d;
  end
`else
  // lowest-index FREE slot
  always_comb begin
    any_free = 1'b0;
    sel = '0;
    for (int i = NUM_WARP - 1; i >= 0; i--)
      if (state_q[i] == W_FREE) begin
        any_free = 1'b1;
        sel = WID_W'(i);
      end
  end
`endif
  assign tpc_req_ready_o = rst_n & any_free & (~lv_q | warp_launch_ready_i);
  assign req_fire = tpc_req_valid_i & tpc_req_ready_o;
  assign launch_fire = lv_q & warp_launch_ready_i;
  assign done_hit = warp_done_valid_i & (state_q[warp_done_wid_i] == W_RUN);
  assign rsp_fire = tpc_rsp_valid_o & tpc_rsp_ready_i;
  assign warp_launch_valid_o = lv_q;
  assign warp_launch_wid_o = lwid_q;
  assign warp_launch_addr_o = laddr_q;
  // per-slot next state; the four events always target distinct slots
  always_comb begin
    for (int i = 0; i < NUM_WARP; i++)
      state_d[i] = (req_fire && sel == WID_W'(i)) ? W_PEND :
                   (launch_fire && lwid_q == WID_W'(i)) ? W_RUN :
                   (done_hit && warp_done_wid_i == WID_W'(i)) ? W_DONE :
                   (rsp_fire && tpc_rsp_wid_o == WID_W'(i)) ? W_FREE : state_q[i];
    lv_d = req_fire | (lv_q & ~warp_launch_ready_i);
    lwid_d = req_fire ? sel : lwid_q;
    laddr_d = req_fire ? tpc_req_start_addr_i : laddr_q;
  end
  // slot states and launch register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_WARP; i++) state_q[i] <= W_FREE;
      lv_q <= 1'b0;
      lwid_q <= '0;
      laddr_q <= '0;
    end else begin
      state_q <= state_d;
      lv_q <= lv_d;
      lwid_q <= lwid_d;
      laddr_q <= laddr_d;
    end
  end
  // active map: any slot not FREE
  always_comb begin
    for (int i = 0; i < NUM_WARP; i++) warp_active_o[i] = state_q[i] != W_FREE;
  end
  sm_wid_fifo #(.DEPTH(NUM_WARP), .WIDTH(WID_W)) u_rsp_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push_i(done_hit),
    .data_i(warp_done_wid_i),
    .pop_i(rsp_fire),
    .valid_o(tpc_rsp_valid_o),
    .data_o(tpc_rsp_wid_o)
  );
endmodule

// File: tb/tb_sm_warp_dispatch.sv
// tb_sm_warp_dispatch: directed vector bench for sm_warp_dispatch with NUM_WARP=4
module tb_sm_warp_dispatch;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic req_v = 1'b0, lrdy = 1'b0, done_v = 1'b0, rsp_rdy = 1'b0;
  logic [31:0] addr = '0;
  logic [1:0] done_wid = '0;
  logic req_rdy, rsp_v, lv;
  logic [1:0] rsp_wid, lwid;
  logic [31:0] laddr;
  logic [3:0] active;
  int checks = 0;
  int failures = 0;

  typedef struct {
    logic rv; logic [31:0] a; logic lr; logic dv; logic [1:0] dw; logic rr;
    logic e_rdy; logic e_lv; logic [1:0] e_lw; logic [31:0] e_la;
    logic e_rsv; logic [1:0] e_rsw; logic [3:0] e_act;
  } vec_t;
  vec_t vt [16];

  sm_warp_dispatch #(.NUM_WARP(4), .CODE_ADDR_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .tpc_req_valid_i(req_v), .tpc_req_ready_o(req_rdy), .tpc_req_start_addr_i(addr),
    .tpc_rsp_valid_o(rsp_v), .tpc_rsp_ready_i(rsp_rdy), .tpc_rsp_wid_o(rsp_wid),
    .warp_launch_valid_o(lv), .warp_launch_ready_i(lrdy), .warp_launch_wid_o(lwid),
    .warp_launch_addr_o(laddr), .warp_done_valid_i(done_v), .warp_done_wid_i(done_wid),
    .warp_active_o(active)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rv, input logic [31:0] a, input logic lr,
                       input logic dv, input logic [1:0] dw, input logic rr);
    req_v = rv; addr = a; lrdy = lr; done_v = dv; done_wid = dw; rsp_rdy = rr;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_lv"}, 32'(lv), 0);
    chk({tag, "_lwid"}, 32'(lwid), 0);
    chk({tag, "_laddr"}, laddr, 0);
    chk({tag, "_rsv"}, 32'(rsp_v), 0);
    chk({tag, "_rsw"}, 32'(rsp_wid), 0);
    chk({tag, "_act"}, 32'(active), 0);
  endtask

  initial begin
    logic [1:0] rr_exp;
    vt[0]  = '{1, 32'h100, 0, 0, 0, 0,  1, 0, 0, 32'h000, 0, 0, 4'b0000};
    vt[1]  = '{0, 32'h000, 0, 0, 0, 0,  0, 1, 0, 32'h100, 0, 0, 4'b0001};
    vt[2]  = '{1, 32'h200, 1, 0, 0, 0,  1, 1, 0, 32'h100, 0, 0, 4'b0001};
    vt[3]  = '{1, 32'h300, 1, 0, 0, 0,  1, 1, 1, 32'h200, 0, 0, 4'b0011};
    vt[4]  = '{1, 32'h400, 1, 0, 0, 0,  1, 1, 2, 32'h300, 0, 0, 4'b0111};
    vt[5]  = '{1, 32'h500, 1, 0, 0, 0,  0, 1, 3, 32'h400, 0, 0, 4'b1111};
    vt[6]  = '{0, 32'h000, 0, 1, 2, 0,  0, 0, 3, 32'h400, 0, 0, 4'b1111};
    vt[7]  = '{0, 32'h000, 0, 1, 0, 0,  0, 0, 3, 32'h400, 1, 2, 4'b1111};
    vt[8]  = '{0, 32'h000, 0, 0, 0, 1,  0, 0, 3, 32'h400, 1, 2, 4'b1111};
    vt[9]  = '{0, 32'h000, 0, 0, 0, 1,  1, 0, 3, 32'h400, 1, 0, 4'b1011};
    vt[10] = '{0, 32'h000, 0, 1, 2, 0,  1, 0, 3, 32'h400, 0, 0, 4'b1010};
    vt[11] = '{1, 32'h600, 0, 0, 0, 0,  1, 0, 3, 32'h400, 0, 0, 4'b1010};
    vt[12] = '{1, 32'h700, 1, 1, 1, 0,  1, 1, 0, 32'h600, 0, 0, 4'b1011};
    vt[13] = '{1, 32'h800, 1, 1, 3, 1,  0, 1, 2, 32'h700, 1, 1, 4'b1111};
    vt[14] = '{1, 32'h800, 1, 1, 0, 1,  1, 0, 2, 32'h700, 1, 3, 4'b1101};
    vt[15] = '{0, 32'h000, 0, 1, 2, 0,  0, 1, 1, 32'h800, 1, 0, 4'b0111};

    #1 rst_n = 1'b0;
    drive(1, 32'h55, 1, 1, 1, 1);
    step();
    chk("rst_rdy", 32'(req_rdy), 0);
    chk_idle("rst");
    drive(0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    #1;
    chk("rel_rdy", 32'(req_rdy), 1);

    for (int i = 0; i < 16; i++) begin
      drive(vt[i].rv, vt[i].a, vt[i].lr, vt[i].dv, vt[i].dw, vt[i].rr);
      #1;
      chk($sformatf("v%0d_rdy", i), 32'(req_rdy), 32'(vt[i].e_rdy));
      chk($sformatf("v%0d_lv", i), 32'(lv), 32'(vt[i].e_lv));
      chk($sformatf("v%0d_lwid", i), 32'(lwid), 32'(vt[i].e_lw));
      chk($sformatf("v%0d_laddr", i), laddr, vt[i].e_la);
      chk($sformatf("v%0d_rsv", i), 32'(rsp_v), 32'(vt[i].e_rsv));
      chk($sformatf("v%0d_rsw", i), 32'(rsp_wid), 32'(vt[i].e_rsw));
      chk($sformatf("v%0d_act", i), 32'(active), 32'(vt[i].e_act));
      step();
    end

    drive(0, 0, 0, 0, 0, 0);
    #1;
    chk("pre_rst_lv", 32'(lv), 1);
    chk("pre_rst_rsv", 32'(rsp_v), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_rdy", 32'(req_rdy), 0);
    chk_idle("mid_rst");
    step();
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 1);
    #1;
    chk("post_rst_rdy", 32'(req_rdy), 1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk_idle($sformatf("post_rst%0d", i));
    end

    drive(0, 0, 0, 1, 3, 0);
    step();
    drive(0, 0, 0, 0, 0, 0);
    #1;
    chk("free_done_rsv", 32'(rsp_v), 0);
    chk("free_done_act", 32'(active), 0);

    drive(1, 32'h10, 1, 0, 0, 0);
    step();
    chk("alloc_lwid", 32'(lwid), 0);
    drive(0, 0, 1, 0, 0, 0);
    step();
    drive(0, 0, 0, 1, 0, 0);
    step();
    drive(0, 0, 0, 0, 0, 1);
    #1;
    chk("free_rsv", 32'(rsp_v), 1);
    chk("free_rsw", 32'(rsp_wid), 0);
    step();
    chk("freed_act", 32'(active), 0);
    drive(1, 32'h20, 0, 0, 0, 0);
    step();
    drive(0, 0, 0, 0, 0, 0);
`ifdef SM_WARP_DISPATCH_RR_EN
    rr_exp = 2'd1;
`else
    rr_exp = 2'd0;
`endif
    chk("realloc_lv", 32'(lv), 1);
    chk("realloc_lwid", 32'(lwid), 32'(rr_exp));
    chk("realloc_laddr", laddr, 32'h20);
    chk("realloc_act", 32'(active), 32'(4'b0001 << rr_exp));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sm_warp_dispatch.md
SM_WARP_DISPATCH -- requirements
Module: sm_warp_dispatch

Interface
REQ-001 SHALL have parameter NUM_WARP, 8, number of warp slots (power of two, 2..32).
REQ-002 SHALL have parameter CODE_ADDR_WIDTH, 32, kernel start-address width.
REQ-003 SHALL have localparam WID_W = $clog2(NUM_WARP), warp-id width.
REQ-004 SHALL have port clk  in  1  system clock; one clock domain only.
REQ-005 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-006 SHALL have port tpc_req_valid_i  in  1  new kernel request from TPC.
REQ-007 SHALL have port tpc_req_ready_o  out  1  request accepted when high with valid.
REQ-008 SHALL have port tpc_req_start_addr_i  in  CODE_ADDR_WIDTH  kernel start address.
REQ-009 SHALL have port tpc_rsp_valid_o  out  1  warp-finished response valid.
REQ-010 SHALL have port tpc_rsp_ready_i  in  1  TPC accepts response.
REQ-011 SHALL have port tpc_rsp_wid_o  out  WID_W  id of finished warp.
REQ-012 SHALL have port warp_launch_valid_o  out  1  launch request to fetch stage.
REQ-013 SHALL have port warp_launch_ready_i  in  1  fetch stage accepts launch.
REQ-014 SHALL have port warp_launch_wid_o  out  WID_W  launched warp id.
REQ-015 SHALL have port warp_launch_addr_o  out  CODE_ADDR_WIDTH  launched warp start PC.
REQ-016 SHALL have port warp_done_valid_i  in  1  pipeline reports warp completion.
REQ-017 SHALL have port warp_done_wid_i  in  WID_W  completing warp id.
REQ-018 SHALL have port warp_active_o  out  NUM_WARP  per-warp bit, 1 = state not FREE.

Function
REQ-019 Each warp slot SHALL hold a state: FREE, PEND, RUN, DONE.
REQ-020 Transitions SHALL be: FREE->PEND on TPC request handshake; PEND->RUN on launch handshake; RUN->DONE on warp_done_valid_i for that wid; DONE->FREE on response handshake for that wid.
REQ-021 tpc_req_ready_o SHALL be high iff at least one slot is FREE and the launch register is empty or handshaking this cycle.
REQ-022 On request handshake in cycle N, warp_launch_valid_o SHALL be high from cycle N+1 with selected wid and captured start address, held stable until warp_launch_ready_i.
REQ-023 A slot freed in cycle N SHALL NOT be selected for allocation before cycle N+1.
REQ-024 warp_done_valid_i for a wid not in RUN SHALL be ignored (no state change, no response).
REQ-025 Completions SHALL push wid into a response FIFO of depth NUM_WARP; FIFO head drives tpc_rsp_valid_o/tpc_rsp_wid_o; responses delivered in completion order.
REQ-026 Simultaneous FIFO push and pop SHALL both take effect; FIFO SHALL never overflow (at most NUM_WARP DONE slots).
REQ-027 Request handshake, launch handshake, completion and response handshake in the same cycle on different slots SHALL all take effect.

Reset
REQ-028 While rst_n low, all slots SHALL be FREE, FIFO empty, launch register empty; tpc_rsp_valid_o=0, warp_launch_valid_o=0, warp_active_o=0, ids/addr=0, tpc_req_ready_o=0.
REQ-029 Reset mid-operation SHALL discard all in-flight launches and responses; tpc_req_ready_o SHALL rise in the first cycle after rst_n deasserts.

Configuration
REQ-030 Macro SM_WARP_DISPATCH_RR_EN defined: allocation SHALL select the first FREE slot searching upward (wrapping) from last-allocated wid + 1; pointer resets to NUM_WARP-1.
REQ-031 Macro undefined: allocation SHALL select the lowest-index FREE slot.

Structure
REQ-032 Warp-state enum and default NUM_WARP/CODE_ADDR_WIDTH SHALL live in the shared sm package alongside existing DEPTH_WARP/CODE_ADDR_WIDTH defines.
REQ-033 The response queue SHALL be a sub-module sm_wid_fifo (parameters DEPTH, WIDTH).

Verification (NUM_WARP=4)
REQ-034 Reset then request addr 0x100 -> launch wid 0 addr 0x100 next cycle; warp_active_o=4'b0001.
REQ-035 Four requests, launch_ready=1 -> wids 0,1,2,3 launched; fifth request sees tpc_req_ready_o=0.
REQ-036 done wids 2,0 with tpc_rsp_ready_i=0, then ready=1 -> responses 2 then 0; warp_active_o=4'b1010 after both.
REQ-037 done for FREE wid 3 -> no response, no state change.
REQ-038 RR_EN on: alloc 0, free 0, request -> wid 1; RR_EN off same stimulus -> wid 0.
REQ-039 rst_n pulsed with launch pending and 2 responses queued -> all outputs at reset values, queued responses never emitted.
